// File: rtl/mult_arbiter_if.sv
// Request, response and multiplier-side signals for the shared multiplier arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface mult_arbiter_if #(
  parameter int unsigned OP_WIDTH = 16
);
  logic                  req0_valid;
  logic [OP_WIDTH-1:0]   req0_a;
  logic [OP_WIDTH-1:0]   req0_b;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [OP_WIDTH-1:0]   req1_a;
  logic [OP_WIDTH-1:0]   req1_b;
  logic                  req1_ready;

  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [2*OP_WIDTH-1:0] rsp_result;
  logic                  rsp_err;

  logic                  mul_start;
  logic [OP_WIDTH-1:0]   mul_a;
  logic [OP_WIDTH-1:0]   mul_b;
  logic                  mul_done;
  logic [2*OP_WIDTH-1:0] mul_result;

  modport master (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_err,
    input  rsp0_ready, rsp1_ready,
    output mul_start, mul_a, mul_b,
    input  mul_done, mul_result
  );

  modport slave (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_err,
    output rsp0_ready, rsp1_ready,
    input  mul_start, mul_a, mul_b,
    output mul_done, mul_result
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier between two requesters,
// with a watchdog that aborts a hung multiplication and reports it as an error response.
module mult_arbiter #(
  parameter int unsigned OP_WIDTH       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_arbiter_if.master       bus_io,
  output logic                 grant_id_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] timeout_count_o
);

  localparam int unsigned PW      = 2 * OP_WIDTH;
  localparam int unsigned WdWidth = $clog2(TIMEOUT_CYCLES);
  localparam logic [WdWidth-1:0] WdLast = WdWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic                 last_grant_q, last_grant_d;
  logic                 grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 mul_start_q, mul_start_d;
  logic                 rsp0_valid_q, rsp0_valid_d;
  logic                 rsp1_valid_q, rsp1_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [OP_WIDTH-1:0]  mul_a_q, mul_a_d;
  logic [OP_WIDTH-1:0]  mul_b_q, mul_b_d;
  logic [PW-1:0]        rsp_result_q, rsp_result_d;
  logic [WdWidth-1:0]   wdog_q, wdog_d;
  logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;

  logic is_idle, pick0, pick1, accept, wd_expired, rsp_ack;

  // On a tie, the requester that was not served last wins.
  assign is_idle    = (state_q == StIdle);
  assign pick1      = bus_io.req1_valid & (~bus_io.req0_valid | ~last_grant_q);
  assign pick0      = bus_io.req0_valid & ~pick1;
  assign accept     = is_idle & (pick0 | pick1);
  assign wd_expired = (wdog_q == WdLast);
  assign rsp_ack    = grant_q ? bus_io.rsp1_ready : bus_io.rsp0_ready;

  assign bus_io.req0_ready = is_idle & pick0;
  assign bus_io.req1_ready = is_idle & pick1;
  assign bus_io.rsp0_valid = rsp0_valid_q;
  assign bus_io.rsp1_valid = rsp1_valid_q;
  assign bus_io.rsp_result = rsp_result_q;
  assign bus_io.rsp_err    = rsp_err_q;
  assign bus_io.mul_start  = mul_start_q;
  assign bus_io.mul_a      = mul_a_q;
  assign bus_io.mul_b      = mul_b_q;
  assign grant_id_o        = grant_q;
  assign busy_o            = busy_q;
  assign timeout_count_o   = tcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      mul_start_q  <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_err_q    <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_result_q <= '0;
      wdog_q       <= '0;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      mul_start_q  <= mul_start_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_err_q    <= rsp_err_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_result_q <= rsp_result_d;
      wdog_q       <= wdog_d;
      tcnt_q       <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StLaunch;
      StLaunch: state_d = StWait;
      StWait:   if (bus_io.mul_done || wd_expired) state_d = StResp;
      StResp:   if (rsp_ack) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    wdog_d       = wdog_q;
    tcnt_d       = tcnt_q;
    mul_start_d  = 1'b0;
    busy_d       = (state_d != StIdle);
    rsp0_valid_d = (state_d == StResp) & ~grant_q;
    rsp1_valid_d = (state_d == StResp) & grant_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          grant_d      = pick1;
          last_grant_d = pick1;
          mul_a_d      = pick1 ? bus_io.req1_a : bus_io.req0_a;
          mul_b_d      = pick1 ? bus_io.req1_b : bus_io.req0_b;
          mul_start_d  = 1'b1;
        end
      end
      StWait: begin
        // A completion landing on the last watchdog cycle still counts as success.
        if (bus_io.mul_done) begin
          rsp_result_d = bus_io.mul_result;
          rsp_err_d    = 1'b0;
        end else if (wd_expired) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          if (tcnt_q != '1) tcnt_d = tcnt_q + CNT_WIDTH'(1);
        end else begin
          wdog_d = wdog_q + WdWidth'(1);
        end
      end
      StResp: begin
        if (rsp_ack) wdog_d = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomised scoreboard bench for mult_arbiter: requester drivers, a behavioural multiplier
// with programmable latency, and a response monitor checking routing, data and latency.
module tb_mult_arbiter;
  localparam int unsigned W  = 16;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned TO = 64;
  localparam int unsigned CW = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           dly;  // cycles from start to done; negative = never completes
  } op_t;

  typedef struct {
    int            port;
    logic [PW-1:0] res;
    logic          err;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic grant_id, busy;
  logic [CW-1:0] tcount;

  always #5 clk = ~clk;

  mult_arbiter_if #(.OP_WIDTH(W)) bus ();

  mult_arbiter #(
    .OP_WIDTH      (W),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus_io         (bus),
    .grant_id_o     (grant_id),
    .busy_o         (busy),
    .timeout_count_o(tcount)
  );

  op_t  pend0[$];
  op_t  pend1[$];
  exp_t exp_q[$];
  int   dly_q[$];
  op_t  cur[2];
  bit   vld[2];
  int   inflight = 0;
  int   model_last = 1;
  int   tout_model = 0;
  int   stall0 = 0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   spur = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input int d);
    op_t o;
    o.a = a;
    o.b = b;
    o.dly = d;
    if (p == 0) pend0.push_back(o);
    else pend1.push_back(o);
    if (d < 0 && tout_model < 255) tout_model++;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((pend0.size() != 0 || pend1.size() != 0 || vld[0] || vld[1] || inflight != 0)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL idle_wait: still busy after %0d cycles, expected idle", n);
    end
    #3;
  endtask

  task automatic check_zero();
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_req1_ready", bus.req1_ready, 0);
    check("rst_rsp0_valid", bus.rsp0_valid, 0);
    check("rst_rsp1_valid", bus.rsp1_valid, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_start", bus.mul_start, 0);
    check("rst_mul_a", bus.mul_a, 0);
    check("rst_mul_b", bus.mul_b, 0);
    check("rst_timeout_count", tcount, 0);
  endtask

  // Requester drivers plus the arbitration reference: who must be accepted this cycle.
  int g;
  bit free;
  initial begin : drv
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    forever begin
      @(negedge clk);
      if (!reset) continue;
      free = (inflight == 0);
      if (!vld[0] && pend0.size() != 0) begin cur[0] = pend0.pop_front(); vld[0] = 1'b1; end
      if (!vld[1] && pend1.size() != 0) begin cur[1] = pend1.pop_front(); vld[1] = 1'b1; end
      bus.req0_valid = vld[0]; bus.req0_a = cur[0].a; bus.req0_b = cur[0].b;
      bus.req1_valid = vld[1]; bus.req1_a = cur[1].a; bus.req1_b = cur[1].b;
      #2;
      if (!reset) continue;
      g = -1;
      if (free) begin
        if (vld[0] && vld[1]) g = (model_last == 0) ? 1 : 0;
        else if (vld[0]) g = 0;
        else if (vld[1]) g = 1;
      end
      check("req0_ready", bus.req0_ready, g == 0);
      check("req1_ready", bus.req1_ready, g == 1);
      if ((g == 0 && bus.req0_ready) || (g == 1 && bus.req1_ready)) begin
        exp_t e;
        e.port = g;
        e.err  = (cur[g].dly < 0);
        e.res  = e.err ? '0 : PW'(cur[g].a) * PW'(cur[g].b);
        e.due  = cyc + 2 + ((cur[g].dly < 0) ? TO : cur[g].dly);
        exp_q.push_back(e);
        dly_q.push_back(cur[g].dly);
        model_last = g;
        vld[g] = 1'b0;
        inflight++;
      end
    end
  end

  // Behavioural multiplier: done pulses a programmed number of cycles after start.
  initial begin : mul
    int cd = 0;
    int d;
    bit prev_start = 1'b0;
    logic [PW-1:0] prod = '0;
    bus.mul_done = 1'b0;
    bus.mul_result = '0;
    forever begin
      @(negedge clk);
      bus.mul_done = 1'b0;
      bus.mul_result = PW'($urandom);
      if (!reset) begin cd = 0; prev_start = 1'b0; continue; end
      if (spur) begin
        bus.mul_done = 1'b1;
        bus.mul_result = 32'hDEAD_BEEF;
        spur = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin bus.mul_done = 1'b1; bus.mul_result = prod; end
      end
      if (bus.mul_start) begin
        check("mul_start_pulse", prev_start, 0);
        if (dly_q.size() == 0) check("unexpected_start", bus.mul_start, 0);
        else begin
          d = dly_q.pop_front();
          prod = PW'(bus.mul_a) * PW'(bus.mul_b);
          cd = (d < 0) ? 0 : d;
        end
      end
      prev_start = bus.mul_start;
    end
  end

  // Response monitor: pops the scoreboard on the first cycle of each response.
  initial begin : mon
    exp_t e;
    bit active = 1'b0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin active = 1'b0; continue; end
      if (stall0 > 0 && bus.rsp0_valid) begin
        bus.rsp0_ready = 1'b0;
        stall0--;
      end else bus.rsp0_ready = ($urandom_range(3) != 0);
      bus.rsp1_ready = ($urandom_range(3) != 0);
      #1;
      if (!reset) continue;
      check("busy", busy, inflight != 0);
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        if (!active) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
          end else begin
            e = exp_q.pop_front();
            active = 1'b1;
            check("rsp_latency", cyc, e.due);
            check("grant_id", grant_id, e.port);
            check("rsp_err", bus.rsp_err, e.err);
          end
        end
        if (active) begin
          check("rsp_route", {bus.rsp1_valid, bus.rsp0_valid}, (e.port == 1) ? 2 : 1);
          check("rsp_result", bus.rsp_result, e.res);
          if ((e.port == 1) ? bus.rsp1_ready : bus.rsp0_ready) begin
            active = 1'b0;
            inflight--;
          end
        end
      end else if (active) begin
        check("rsp_dropped", {bus.rsp1_valid, bus.rsp0_valid}, (e.port == 1) ? 2 : 1);
        active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int n;
    repeat (2) @(negedge clk);
    #1;
    check_zero();
    #2;
    reset = 1'b1;

    push(0, 16'd3, 16'd5, 4);
    wait_idle(200);

    for (int i = 0; i < 3; i++) begin
      push(0, W'(i + 1), 16'd7, 2);
      push(1, W'(i + 10), 16'd3, 3);
    end
    wait_idle(400);

    push(0, 16'hFFFF, 16'hFFFF, 3);
    push(1, 16'h0000, 16'h1234, 1);
    wait_idle(200);

    stall0 = 10;
    push(0, 16'd9, 16'd9, 2);
    n = 0;
    while (inflight == 0 && n < 50) begin @(negedge clk); n++; end
    #3;
    push(1, 16'd4, 16'd4, 1);
    wait_idle(200);

    // Completion on the final watchdog cycle must win over the abort.
    push(0, 16'h1111, 16'h0002, TO);
    wait_idle(300);

    push(1, 16'd5, 16'd5, -1);
    wait_idle(300);
    check("timeout_count_1", tcount, tout_model);
    push(1, 16'd6, 16'd7, 3);
    wait_idle(200);

    for (int i = 0; i < 40; i++) begin
      int d;
      d = $urandom_range(8, 1);
      if ($urandom_range(15) == 0) d = -1;
      push($urandom_range(1), W'($urandom), W'($urandom), d);
      if ($urandom_range(3) == 0) wait_idle(400);
      else begin
        repeat ($urandom_range(3)) @(negedge clk);
        #3;
      end
    end
    wait_idle(3000);
    check("timeout_count_rand", tcount, tout_model);

    for (int i = 0; i < 255; i++) push(i % 2, W'(i), W'(i + 1), -1);
    wait_idle(20000);
    check("timeout_count_sat", tcount, 255);

    // Asynchronous reset in the middle of a hung multiplication.
    push(0, 16'd2, 16'd3, -1);
    n = 0;
    while (!bus.mul_start && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #3;
    reset = 1'b0;
    pend0.delete(); pend1.delete(); exp_q.delete(); dly_q.delete();
    vld[0] = 1'b0; vld[1] = 1'b0;
    inflight = 0; model_last = 1; tout_model = 0; stall0 = 0;
    #1;
    check_zero();
    @(negedge clk);
    #3;
    reset = 1'b1;
    spur = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("spur_result", bus.rsp_result, 0);
    check("spur_busy", busy, 0);
    #2;
    push(0, 16'd7, 16'd8, 2);
    push(1, 16'd9, 16'd9, 2);
    wait_idle(200);
    check("timeout_count_end", tcount, tout_model);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
